// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART frame serialiser (start, LSB-first data, optional parity, stop bits)
module uart_transmitter #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 clken,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] din,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t                state;
  logic [TW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_BITS-1:0]  shift_reg;
  logic                  par_bit;
  logic                  cur_bit;

  // Level that belongs on the line for the bit currently being sent.
  always_comb begin
    cur_bit = 1'b1;
    case (state)
      START:   cur_bit = 1'b0;
      DATA:    cur_bit = shift_reg[0];
      PAR:     cur_bit = par_bit;
      default: cur_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          tick_cnt <= '0;
          bit_cnt  <= '0;
          // A write landing in the completion cycle is dropped, not queued.
          if (wr_en && !tx_busy && !tx_done) begin
            shift_reg <= din;
            par_bit   <= (PARITY == 1) ? ~(^din) : ^din;
            tx_busy   <= 1'b1;
            state     <= START;
          end
        end

        START, DATA, PAR, STOP: begin
          if (clken) begin
            if (tick_cnt == '0) tx <= cur_bit;
            if (tick_cnt != TICK_LAST) begin
              tick_cnt <= tick_cnt + 1'b1;
            end else begin
              tick_cnt <= '0;
              case (state)
                START: begin
                  bit_cnt <= '0;
                  state   <= DATA;
                end
                DATA: begin
                  shift_reg <= shift_reg >> 1;
                  if (bit_cnt == DATA_LAST) begin
                    bit_cnt <= '0;
                    state   <= (PARITY != 0) ? PAR : STOP;
                  end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                  end
                end
                PAR: begin
                  bit_cnt <= '0;
                  state   <= STOP;
                end
                default: begin
                  if (bit_cnt == STOP_LAST) begin
                    bit_cnt <= '0;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                    state   <= IDLE;
                  end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                  end
                end
              endcase
            end
          end
        end

        default: begin
          state   <= IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
